// File: rtl/ads1292_filtered_uart_tx.sv
// ads1292_filtered_uart_tx: sends each filtered sample as a UART frame (sync byte, then data bytes MSB first).
module ads1292_filtered_uart_tx #(
   parameter int unsigned CLKS_PER_BIT = 434,
   parameter logic [7:0]  SYNC_BYTE    = 8'hAA
) (
   input  logic        i_CLK,
   input  logic        i_RSTN,
   input  logic [31:0] i_ADS1292_FILTERED_DATA,
   input  logic        i_ADS1292_FILTERED_DATA_VALID,
   output logic        o_ADS1292_FILTERED_DATA_ACK,
   output logic        o_UART_TX,
   output logic        o_BUSY,
   output logic [15:0] o_FRAME_CNT
);
   localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
   state_t state, state_n;
   logic [CW-1:0] baud, baud_n;
   logic [2:0] bit_idx, bit_n, byte_idx, byte_n;
   logic [7:0] shift, shift_n;
   logic [31:0] hold, hold_n;
   logic [15:0] frame_cnt, cnt_n;
   logic ack, ack_n, busy, busy_n, tx, tx_n, last, capture;
   always_comb begin
      last = baud == BAUD_LAST;
      state_n = state;
      baud_n = (last || state == IDLE) ? '0 : baud + 1'b1;
      bit_n = bit_idx;
      byte_n = byte_idx;
      shift_n = shift;
      hold_n = hold;
      ack_n = 1'b0;
      busy_n = busy;
      tx_n = tx;
      cnt_n = frame_cnt;
      case (state)
         START: if (last) begin
            state_n = DATA;
            bit_n = 3'd0;
            tx_n = shift[0];
         end
         DATA: if (last) begin
            bit_n = bit_idx + 3'd1;
            state_n = (bit_idx == 3'd7) ? STOP : DATA;
            tx_n = (bit_idx == 3'd7) ? 1'b1 : shift[bit_idx + 3'd1];
         end
         STOP: if (last) begin
            if (byte_idx != 3'd4) begin
               byte_n = byte_idx + 3'd1;
               shift_n = (byte_idx == 3'd0) ? hold[31:24] :
                         (byte_idx == 3'd1) ? hold[23:16] :
                         (byte_idx == 3'd2) ? hold[15:8]  : hold[7:0];
               state_n = START;
               tx_n = 1'b0;
            end else begin
               cnt_n = frame_cnt + 16'd1;
               busy_n = 1'b0;
               state_n = IDLE;
               tx_n = 1'b1;
            end
         end
         default: tx_n = 1'b1;
      endcase
      // the last stop-bit edge doubles as an idle edge so frames can run back to back
      capture = i_ADS1292_FILTERED_DATA_VALID &&
                (state == IDLE || (state == STOP && last && byte_idx == 3'd4));
      if (capture) begin
         hold_n = i_ADS1292_FILTERED_DATA;
         shift_n = SYNC_BYTE;
         byte_n = 3'd0;
         ack_n = 1'b1;
         busy_n = 1'b1;
         state_n = START;
         tx_n = 1'b0;
         baud_n = '0;
      end
   end
   always_ff @(posedge i_CLK or negedge i_RSTN) begin
      if (!i_RSTN) begin
         state <= IDLE;
         baud <= '0;
         bit_idx <= 3'd0;
         byte_idx <= 3'd0;
         shift <= 8'd0;
         hold <= 32'd0;
         frame_cnt <= 16'd0;
         ack <= 1'b0;
         busy <= 1'b0;
         tx <= 1'b1;
      end else begin
         state <= state_n;
         baud <= baud_n;
         bit_idx <= bit_n;
         byte_idx <= byte_n;
         shift <= shift_n;
         hold <= hold_n;
         frame_cnt <= cnt_n;
         ack <= ack_n;
         busy <= busy_n;
         tx <= tx_n;
      end
   end
   assign o_ADS1292_FILTERED_DATA_ACK = ack;
   assign o_UART_TX = tx;
   assign o_BUSY = busy;
   assign o_FRAME_CNT = frame_cnt;
endmodule
